// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encoding,
// flag bit positions, controller states and the default flags reset value.
package alu_arb_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_OR  = 3'd1,
    OP_NOT = 3'd2,
    OP_DAA = 3'd3,
    OP_AND = 3'd4,
    OP_CLD = 3'd5,
    OP_SUB = 3'd6,
    OP_STD = 3'd7
  } alu_op_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [31:0] FLAGS_RST_DEFAULT = 32'h0000_0002;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection. Round-robin when ALU_ARB_RR_EN is defined,
// otherwise fixed priority to requester 0 (no pointer state at all).
module rr_arb2 (
`ifdef ALU_ARB_RR_EN
  input  logic       CLK,
  input  logic       CLR,
  input  logic       accept,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  // last_reg = id granted most recently; starts at 1 so requester 0 wins first
  logic last_reg;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      last_reg <= 1'b1;
    end else if (accept) begin
      last_reg <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_reg ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu32_arbiter.sv
// Shares one combinational alu32 between two requesters with a
// one-op-in-flight IDLE/EXEC/RESP controller. Option: ALU_ARB_RR_EN.
module alu32_arbiter
  import alu_arb_pkg::*;
#(
  parameter logic [31:0] FLAGS_RST = FLAGS_RST_DEFAULT
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_flags_in,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_flags,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_flags,
  input  logic        rsp_ready
);

  state_e      state_reg, state_next;
  alu_op_e     op_reg;
  logic [31:0] a_reg, b_reg;
  logic        id_reg;
  logic [31:0] flags_reg;
  logic [31:0] flags_in_reg;
  logic [31:0] result_reg;
  logic [1:0]  grant;
  logic        accept;

  rr_arb2 u_arb (
`ifdef ALU_ARB_RR_EN
    .CLK    (CLK),
    .CLR    (CLR),
    .accept (accept),
`endif
    .req    ({req1_valid, req0_valid}),
    .grant  (grant)
  );

  assign accept = (state_reg == ST_IDLE) && (grant != 2'b00);

  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (accept) state_next = ST_EXEC;
      end
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand and flags-in registers change only on accept, so the ALU inputs
  // naturally hold their last values outside EXEC.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_ADD;
      a_reg        <= '0;
      b_reg        <= '0;
      id_reg       <= 1'b0;
      flags_reg    <= FLAGS_RST;
      flags_in_reg <= FLAGS_RST;
      result_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg       <= alu_op_e'(grant[1] ? req1_op : req0_op);
        a_reg        <= grant[1] ? req1_a : req0_a;
        b_reg        <= grant[1] ? req1_b : req0_b;
        id_reg       <= grant[1];
        flags_in_reg <= flags_reg;
      end
      if (state_reg == ST_EXEC) begin
        result_reg <= alu_out;
        flags_reg  <= alu_flags;
      end
    end
  end

  assign alu_op       = op_reg;
  assign alu_a        = a_reg;
  assign alu_b        = b_reg;
  assign alu_flags_in = flags_in_reg;
  assign rsp_id       = id_reg;
  assign rsp_result   = result_reg;
  assign rsp_flags    = flags_reg;

endmodule

// File: doc/alu32_arbiter.md
ALU32_ARBITER -- requirements
Module: alu32_arbiter

Interface
REQ-001 SHALL have parameter FLAGS_RST, default 32'h0000_0002, giving the reset value of the held flags register.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port CLR  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op  input  3 each  ALU op: 0 ADD, 1 OR, 2 NOT, 3 DAA, 4 AND, 5 CLD, 6 SUB (b-a), 7 STD.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-008 SHALL have ports alu_op (output, 3), alu_a (output, 32), alu_b (output, 32) and alu_flags_in (output, 32), which drive the shared alu32.
REQ-009 SHALL have ports alu_out (input, 32) and alu_flags (input, 32), carrying the combinational alu32 result and its updated flags.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_result (output, 32), rsp_flags (output, 32) and rsp_ready (input, 1).

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-012 SHALL, in IDLE, assert reqN_ready only for the granted requester; grant requires reqN_valid; ready SHALL be 0 in EXEC and RESP.
REQ-013 SHALL, on accept (valid&ready, cycle N), latch op, a, b and the winner id, then enter EXEC at N+1.
REQ-014 SHALL, in EXEC, drive alu_op/alu_a/alu_b from the latched values and alu_flags_in from the flags register; elsewhere these outputs SHALL hold their last values.
REQ-015 SHALL, at the end of EXEC, register alu_out into rsp_result, write alu_flags into the flags register for every op, and enter RESP.
REQ-016 SHALL assert rsp_valid in RESP only (first at cycle N+2), with rsp_flags equal to the updated flags register.
REQ-017 SHALL hold rsp_id, rsp_result and rsp_flags stable while rsp_valid & !rsp_ready.
REQ-018 SHALL leave RESP for IDLE on the cycle rsp_valid & rsp_ready; the earliest next accept is that IDLE cycle, giving a 3-cycle minimum issue interval.
REQ-019 SHALL, when both requests are valid in IDLE, grant according to REQ-027/028; when only one is valid, grant that one.
REQ-020 SHALL update the last-grant pointer only on accept.
REQ-021 SHALL ignore op encoding beyond passing it through; flag semantics are the ALU's responsibility.

Reset
REQ-022 SHALL, on CLR at any state (including mid-EXEC or RESP), enter IDLE next cycle and discard the pending op without emitting a response.
REQ-023 SHALL, on reset, drive rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=FLAGS_RST and flags register=FLAGS_RST.
REQ-024 SHALL, on reset, drive alu_op=0, alu_a=0, alu_b=0 and alu_flags_in=FLAGS_RST.
REQ-025 SHALL reset the last-grant pointer to 1, so req0 wins the first contention.
REQ-026 SHALL give CLR priority over any simultaneous accept or response handshake.

Configuration
REQ-027 SHALL, with ALU_ARB_RR_EN defined, grant the requester not granted last on contention (round-robin).
REQ-028 SHALL, without ALU_ARB_RR_EN, always grant req0 on contention (fixed priority); the last-grant pointer SHALL be absent.

Structure
REQ-029 SHALL take from shared package alu_arb_pkg: the op encoding enum, flag bit indices (CF 0, PF 2, AF 4, ZF 6, SF 7, DF 10, OF 11), the FSM state enum and the FLAGS_RST default.
REQ-030 SHALL isolate grant logic in sub-module rr_arb2 (2-way arbiter; round-robin/fixed selection via ALU_ARB_RR_EN).

Verification
REQ-031 SHALL cover: CLR held 2 cycles -> rsp_valid=0, both ready=0 with no valid, rsp_flags=32'h2.
REQ-032 SHALL cover: req0 ADD a=1, b=2 accepted at N -> alu_op=0 at N+1; rsp_valid at N+2 with rsp_id=0, rsp_result=3, rsp_flags[0]=0.
REQ-033 SHALL cover: req0 ADD a=32'hFFFFFFFF, b=1, then req1 CLD -> first rsp CF=1, ZF=1; during second EXEC alu_flags_in[0]=1, and the second response has rsp_flags[10]=0 and rsp_id=1.
REQ-034 SHALL cover: both valid continuously, rsp_ready=1 -> grants 0,1,0,1 with ALU_ARB_RR_EN; 0,0,0,0 without.
REQ-035 SHALL cover: rsp_ready=0 for 5 cycles in RESP -> response fields constant, req ready=0 throughout; accept occurs the cycle after rsp_ready rises.
REQ-036 SHALL cover: CLR asserted during EXEC of an op -> no rsp_valid follows, flags register=32'h2, next accept in IDLE proceeds normally.
